// File: rtl/rcb_spi_regbank_if.sv
// Decoded-transaction bus between the RCB SPI slave and its register bank.
// The master side is the SPI slave; the register bank takes the slave modport.
interface rcb_spi_regbank_if;
    logic [15:0] addr;
    logic        addr_rdy;
    logic [31:0] data_mosi;
    logic        data_mosi_rdy;
    logic        data_miso_rdy;
    logic [31:0] data_miso;

    modport master (
        output addr, addr_rdy, data_mosi, data_mosi_rdy, data_miso_rdy,
        input  data_miso
    );

    modport slave (
        input  addr, addr_rdy, data_mosi, data_mosi_rdy, data_miso_rdy,
        output data_miso
    );
endinterface

// File: rtl/rcb_spi_regbank.sv
// RCB register bank: version/scratch/status/IRQ/lock/error-counter registers plus
// NUM_RW lockable control registers, accessed through decoded SPI transactions.
module rcb_spi_regbank #(
    parameter int          NUM_RW     = 8,
    parameter logic [31:0] VERSION    = 32'h0001_0000,
    parameter logic [31:0] UNLOCK_KEY = 32'hA5A5_5A5A
) (
    input  logic                  clk_100m,
    input  logic                  rst_syn,
    rcb_spi_regbank_if.slave      spi,
    input  logic [31:0]           status_in,
    input  logic [31:0]           irq_evt,
    output logic [NUM_RW*32-1:0]  ctrl_regs,
    output logic [NUM_RW-1:0]     ctrl_wr_stb,
    output logic                  irq_out,
    output logic                  unlocked,
    output logic                  acc_err
);

    localparam logic [15:0] ADDR_VERSION = 16'h0000;
    localparam logic [15:0] ADDR_SCRATCH = 16'h0001;
    localparam logic [15:0] ADDR_STATUS  = 16'h0002;
    localparam logic [15:0] ADDR_IRQ_FLG = 16'h0003;
    localparam logic [15:0] ADDR_IRQ_MSK = 16'h0004;
    localparam logic [15:0] ADDR_LOCK    = 16'h0005;
    localparam logic [15:0] ADDR_ERR_CNT = 16'h0006;
    localparam logic [15:0] CTRL_BASE    = 16'h0010;

    typedef enum logic [1:0] {ST_IDLE, ST_CAPT, ST_LOAD, ST_ARMED} state_t;

    state_t      state_reg;
    logic        addr_rdy_prev_reg;
    logic [15:0] cur_addr_reg;
    logic [31:0] data_miso_reg;
    logic [31:0] scratch_reg;
    logic [31:0] irq_flags_reg;
    logic [31:0] irq_mask_reg;
    logic [15:0] err_cnt_reg;
    logic        unlocked_reg;
    logic        acc_err_reg;
    logic        irq_out_reg;

    logic              addr_rise;
    logic              wr_fire;
    logic              rd_done;
    logic              stray_wr;
    logic              mapped;
    logic              wr_err;
    logic              rd_err;
    logic              any_err;
    logic              err_clr;
    logic              ctrl_wr_ok;
    logic [31:0]       w1c_mask;
    logic [31:0]       rd_mux;
    logic [NUM_RW-1:0] ctrl_hit;

    assign addr_rise = spi.addr_rdy & ~addr_rdy_prev_reg;
    assign wr_fire   = (state_reg == ST_ARMED) && spi.data_mosi_rdy;
    assign rd_done   = (state_reg == ST_ARMED) && !spi.data_mosi_rdy && spi.data_miso_rdy;
    assign stray_wr  = (state_reg != ST_ARMED) && spi.data_mosi_rdy;
    assign mapped    = (cur_addr_reg <= ADDR_ERR_CNT) || (|ctrl_hit);

    // Writes are rejected for read-only, unmapped, or locked control addresses.
    assign wr_err  = wr_fire && ((cur_addr_reg == ADDR_VERSION) || (cur_addr_reg == ADDR_STATUS) ||
                                 !mapped || ((|ctrl_hit) && !unlocked_reg));
    assign rd_err  = rd_done && !mapped;
    assign any_err = wr_err || rd_err || stray_wr;
    assign err_clr = wr_fire && (cur_addr_reg == ADDR_ERR_CNT);
    assign ctrl_wr_ok = wr_fire && unlocked_reg;
    assign w1c_mask   = (wr_fire && (cur_addr_reg == ADDR_IRQ_FLG)) ? spi.data_mosi : 32'h0;

    always_comb begin
        rd_mux = 32'hDEAD_BEEF;
        case (cur_addr_reg)
            ADDR_VERSION: rd_mux = VERSION;
            ADDR_SCRATCH: rd_mux = scratch_reg;
            ADDR_STATUS:  rd_mux = status_in;
            ADDR_IRQ_FLG: rd_mux = irq_flags_reg;
            ADDR_IRQ_MSK: rd_mux = irq_mask_reg;
            ADDR_LOCK:    rd_mux = {31'b0, unlocked_reg};
            ADDR_ERR_CNT: rd_mux = {16'b0, err_cnt_reg};
            default:      ;
        endcase
        for (int k = 0; k < NUM_RW; k++) begin
            if (ctrl_hit[k]) rd_mux = ctrl_regs[32*k +: 32];
        end
    end

    // Transaction FSM; data_miso is loaded once per transaction and held until the next LOAD.
    always_ff @(posedge clk_100m) begin
        if (rst_syn) begin
            state_reg         <= ST_IDLE;
            addr_rdy_prev_reg <= 1'b0;
            cur_addr_reg      <= 16'h0;
            data_miso_reg     <= 32'h0;
        end else begin
            addr_rdy_prev_reg <= spi.addr_rdy;
            case (state_reg)
                ST_IDLE: if (addr_rise) state_reg <= ST_CAPT;
                ST_CAPT: begin
                    cur_addr_reg <= spi.addr;
                    state_reg    <= ST_LOAD;
                end
                ST_LOAD: begin
                    data_miso_reg <= rd_mux;
                    state_reg     <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (spi.data_mosi_rdy || spi.data_miso_rdy) state_reg <= ST_IDLE;
                    else if (addr_rise)                          state_reg <= ST_CAPT;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100m) begin
        if (rst_syn) begin
            scratch_reg   <= 32'h0;
            irq_flags_reg <= 32'h0;
            irq_mask_reg  <= 32'h0;
            err_cnt_reg   <= 16'h0;
            unlocked_reg  <= 1'b0;
            acc_err_reg   <= 1'b0;
            irq_out_reg   <= 1'b0;
        end else begin
            acc_err_reg   <= any_err;
            // New events override a same-cycle W1C of the same bit.
            irq_flags_reg <= (irq_flags_reg & ~w1c_mask) | irq_evt;
            irq_out_reg   <= |(irq_flags_reg & irq_mask_reg);
            if (err_clr)
                err_cnt_reg <= 16'h0;
            else if (any_err && (err_cnt_reg != 16'hFFFF))
                err_cnt_reg <= err_cnt_reg + 16'd1;
            if (wr_fire) begin
                case (cur_addr_reg)
                    ADDR_SCRATCH: scratch_reg  <= spi.data_mosi;
                    ADDR_IRQ_MSK: irq_mask_reg <= spi.data_mosi;
                    ADDR_LOCK:    unlocked_reg <= (spi.data_mosi == UNLOCK_KEY);
                    default:      ;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_ctrl
            logic [31:0] val_reg;
            logic        stb_reg;

            assign ctrl_hit[gi] = (cur_addr_reg == CTRL_BASE + 16'(gi));

            always_ff @(posedge clk_100m) begin
                if (rst_syn) begin
                    val_reg <= 32'h0;
                    stb_reg <= 1'b0;
                end else begin
                    stb_reg <= ctrl_wr_ok && ctrl_hit[gi];
                    if (ctrl_wr_ok && ctrl_hit[gi]) val_reg <= spi.data_mosi;
                end
            end

            assign ctrl_regs[32*gi +: 32] = val_reg;
            assign ctrl_wr_stb[gi]        = stb_reg;
        end
    endgenerate

    assign spi.data_miso = data_miso_reg;
    assign irq_out       = irq_out_reg;
    assign unlocked      = unlocked_reg;
    assign acc_err       = acc_err_reg;

endmodule

// File: tb/tb_rcb_spi_regbank.sv
// Scoreboard bench for rcb_spi_regbank: a driver issues SPI-style transactions and
// pushes model predictions; two monitors pop and compare when the DUT responds.
module tb_rcb_spi_regbank;

    localparam int          NUM_RW = 8;
    localparam int          CW     = NUM_RW * 32;
    localparam logic [31:0] KEY    = 32'hA5A5_5A5A;
    localparam logic [31:0] VER    = 32'h0001_0000;

    logic              clk_100m;
    logic              rst_syn;
    logic [31:0]       status_in;
    logic [31:0]       irq_evt;
    logic [CW-1:0]     ctrl_regs;
    logic [NUM_RW-1:0] ctrl_wr_stb;
    logic              irq_out;
    logic              unlocked;
    logic              acc_err;

    rcb_spi_regbank_if spi_if ();

    rcb_spi_regbank #(.NUM_RW(NUM_RW), .VERSION(VER), .UNLOCK_KEY(KEY)) dut (
        .clk_100m    (clk_100m),
        .rst_syn     (rst_syn),
        .spi         (spi_if.slave),
        .status_in   (status_in),
        .irq_evt     (irq_evt),
        .ctrl_regs   (ctrl_regs),
        .ctrl_wr_stb (ctrl_wr_stb),
        .irq_out     (irq_out),
        .unlocked    (unlocked),
        .acc_err     (acc_err)
    );

    initial clk_100m = 1'b0;
    always #5 clk_100m = ~clk_100m;

    typedef struct {
        logic [31:0] miso;
        logic        irq;
    } miso_exp_t;

    typedef struct {
        logic              err;
        logic [NUM_RW-1:0] stb;
        logic [CW-1:0]     ctrl;
        logic              unl;
    } resp_exp_t;

    miso_exp_t q_miso[$];
    resp_exp_t q_resp[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model state: the register map as plain variables.
    logic [31:0] m_scratch, m_flags, m_mask;
    logic [15:0] m_errcnt;
    logic        m_unl;
    logic [31:0] m_ctrl [NUM_RW];

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_scratch = 0; m_flags = 0; m_mask = 0; m_errcnt = 0; m_unl = 0;
        for (int k = 0; k < NUM_RW; k++) m_ctrl[k] = 0;
    endtask

    function automatic bit is_ctrl(input logic [15:0] a);
        return (a >= 16'h0010) && (a < 16'(16 + NUM_RW));
    endfunction

    function automatic bit is_mapped(input logic [15:0] a);
        return (a <= 16'h0006) || is_ctrl(a);
    endfunction

    function automatic logic [CW-1:0] model_ctrl_flat();
        logic [CW-1:0] f;
        for (int k = 0; k < NUM_RW; k++) f[32*k +: 32] = m_ctrl[k];
        return f;
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        if (is_ctrl(a)) return m_ctrl[a - 16'h0010];
        case (a)
            16'h0000: return VER;
            16'h0001: return m_scratch;
            16'h0002: return status_in;
            16'h0003: return m_flags;
            16'h0004: return m_mask;
            16'h0005: return {31'b0, m_unl};
            16'h0006: return {16'b0, m_errcnt};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic model_err_event(input bit err, input bit clr);
        if (clr) m_errcnt = 0;
        else if (err && m_errcnt != 16'hFFFF) m_errcnt = m_errcnt + 1;
    endtask

    // Apply one completed access to the model and queue the predicted response.
    task automatic model_access(input logic [15:0] a, input bit wr, input logic [31:0] d,
                                input logic [31:0] evt);
        bit err = 0, clr = 0;
        resp_exp_t r;
        r.stb = '0;
        if (wr) begin
            if (is_ctrl(a)) begin
                if (m_unl) begin
                    m_ctrl[a - 16'h0010] = d;
                    r.stb[a - 16'h0010] = 1'b1;
                end else err = 1;
            end else begin
                case (a)
                    16'h0001: m_scratch = d;
                    16'h0003: m_flags = m_flags & ~d;
                    16'h0004: m_mask = d;
                    16'h0005: m_unl = (d == KEY);
                    16'h0006: clr = 1;
                    default:  err = 1;
                endcase
            end
        end else begin
            err = !is_mapped(a);
        end
        m_flags = m_flags | evt;
        model_err_event(err, clr);
        r.err = err; r.ctrl = model_ctrl_flat(); r.unl = m_unl;
        q_resp.push_back(r);
    endtask

    task automatic start_addr(input logic [15:0] a);
        miso_exp_t e;
        @(negedge clk_100m);
        status_in = $urandom;
        spi_if.addr = 16'($urandom);
        spi_if.addr_rdy = 1'b1;
        e.miso = model_read(a);
        e.irq  = |(m_flags & m_mask);
        q_miso.push_back(e);
        @(negedge clk_100m);
        spi_if.addr = a;
        repeat (14) @(negedge clk_100m);
        spi_if.addr_rdy = 1'b0;
        repeat (4) @(negedge clk_100m);
    endtask

    task automatic txn(input logic [15:0] a, input bit wr, input logic [31:0] d, input logic [31:0] evt);
        start_addr(a);
        model_access(a, wr, d, evt);
        if (wr) begin
            spi_if.data_mosi = d;
            spi_if.data_mosi_rdy = 1'b1;
        end else begin
            spi_if.data_miso_rdy = 1'b1;
        end
        irq_evt = evt;
        @(negedge clk_100m);
        spi_if.data_mosi_rdy = 1'b0;
        spi_if.data_miso_rdy = 1'b0;
        irq_evt = 32'h0;
        repeat (4) @(negedge clk_100m);
    endtask

    task automatic abort_txn(input logic [15:0] a1, input logic [15:0] a2, input bit wr, input logic [31:0] d);
        start_addr(a1);
        txn(a2, wr, d, 32'h0);
    endtask

    task automatic stray_write();
        resp_exp_t r;
        @(negedge clk_100m);
        model_err_event(1, 0);
        r.err = 1; r.stb = '0; r.ctrl = model_ctrl_flat(); r.unl = m_unl;
        q_resp.push_back(r);
        spi_if.data_mosi = $urandom;
        spi_if.data_mosi_rdy = 1'b1;
        @(negedge clk_100m);
        spi_if.data_mosi_rdy = 1'b0;
        repeat (3) @(negedge clk_100m);
    endtask

    task automatic pulse_evt(input logic [31:0] e);
        @(negedge clk_100m);
        irq_evt = e;
        m_flags = m_flags | e;
        @(negedge clk_100m);
        irq_evt = 32'h0;
        repeat (3) @(negedge clk_100m);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_miso"}, CW'(spi_if.data_miso), '0);
        check({tag, "_ctrl_regs"}, ctrl_regs, '0);
        check({tag, "_ctrl_wr_stb"}, CW'(ctrl_wr_stb), '0);
        check({tag, "_flags"}, CW'({irq_out, unlocked, acc_err}), '0);
    endtask

    // Monitor: data_miso and irq_out three cycles after each addr_rdy rise.
    initial begin : mon_miso
        logic prev;
        miso_exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk_100m);
            if (!rst_syn && spi_if.addr_rdy && !prev) begin
                prev = 1'b1;
                @(posedge clk_100m);
                @(posedge clk_100m);
                #1;
                if (q_miso.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL miso_scoreboard: got no expected entry, required one");
                end else begin
                    e = q_miso.pop_front();
                    check("data_miso", CW'(spi_if.data_miso), CW'(e.miso));
                    check("irq_out", CW'(irq_out), CW'(e.irq));
                end
            end else begin
                prev = spi_if.addr_rdy;
            end
        end
    end

    // Monitor: write/read-complete response, visible right after the sampling edge.
    initial begin : mon_resp
        resp_exp_t r;
        forever begin
            @(posedge clk_100m);
            if (!rst_syn && (spi_if.data_mosi_rdy || spi_if.data_miso_rdy)) begin
                #1;
                if (q_resp.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL resp_scoreboard: got no expected entry, required one");
                end else begin
                    r = q_resp.pop_front();
                    check("acc_err", CW'(acc_err), CW'(r.err));
                    check("ctrl_wr_stb", CW'(ctrl_wr_stb), CW'(r.stb));
                    check("ctrl_regs", ctrl_regs, r.ctrl);
                    check("unlocked", CW'(unlocked), CW'(r.unl));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [15:0] a;
        logic [31:0] d;
        bit          wr;
        rst_syn = 1'b1;
        status_in = 32'h0; irq_evt = 32'h0;
        spi_if.addr = 16'h0; spi_if.addr_rdy = 1'b0; spi_if.data_mosi = 32'h0;
        spi_if.data_mosi_rdy = 1'b0; spi_if.data_miso_rdy = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_100m);
        check_all_zero("reset");
        rst_syn = 1'b0;
        repeat (2) @(negedge clk_100m);

        txn(16'h0000, 0, 0, 0);
        txn(16'h0010, 1, 32'h1234_5678, 0);
        txn(16'h0006, 0, 0, 0);
        txn(16'h0005, 1, KEY, 0);
        txn(16'h0010, 1, 32'h1234_5678, 0);
        txn(16'h0010, 0, 0, 0);

        txn(16'h0004, 1, 32'h8, 0);
        pulse_evt(32'h8);
        txn(16'h0003, 0, 0, 0);
        txn(16'h0003, 1, 32'h8, 32'h8);
        txn(16'h0003, 0, 0, 0);
        txn(16'h0003, 1, 32'h8, 0);
        txn(16'h0003, 0, 0, 0);

        txn(16'h7777, 0, 0, 0);
        txn(16'h0006, 0, 0, 0);
        @(negedge clk_100m);
        force dut.err_cnt_reg = 16'hFFFF;
        m_errcnt = 16'hFFFF;
        @(negedge clk_100m);
        release dut.err_cnt_reg;
        stray_write();
        txn(16'h0006, 0, 0, 0);
        txn(16'h0006, 1, $urandom, 0);
        txn(16'h0006, 0, 0, 0);

        abort_txn(16'h0011, 16'h0001, 1, 32'hCAFE_F00D);
        txn(16'h0011, 0, 0, 0);
        txn(16'h0001, 0, 0, 0);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                7, 8:    a = 16'(16 + $urandom_range(0, NUM_RW - 1));
                9:       a = 16'($urandom_range(16 + NUM_RW, 65535));
                default: a = 16'($urandom_range(0, 6));
            endcase
            wr = bit'($urandom_range(0, 1));
            d  = (a == 16'h0005 && $urandom_range(0, 2) != 0) ? KEY : $urandom;
            if ($urandom_range(0, 4) == 0) pulse_evt(32'h1 << $urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) stray_write();
            if ($urandom_range(0, 9) == 0) abort_txn(16'($urandom), a, wr, d);
            else txn(a, wr, d, ($urandom_range(0, 5) == 0) ? $urandom : 32'h0);
        end

        txn(16'h0005, 1, KEY, 0);
        txn(16'h0012, 1, 32'h5555_AAAA, 0);
        start_addr(16'h0012);
        rst_syn = 1'b1;
        @(negedge clk_100m);
        spi_if.data_mosi = 32'hFFFF_FFFF;
        spi_if.data_mosi_rdy = 1'b1;
        @(negedge clk_100m);
        spi_if.data_mosi_rdy = 1'b0;
        rst_syn = 1'b0;
        q_resp.delete();
        model_reset();
        check_all_zero("mid_txn_reset");
        repeat (2) @(negedge clk_100m);
        txn(16'h0006, 0, 0, 0);
        txn(16'h0000, 0, 0, 0);

        repeat (10) @(negedge clk_100m);
        check("miso_queue_left", CW'(q_miso.size()), '0);
        check("resp_queue_left", CW'(q_resp.size()), '0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
